// File: rtl/regfile_access_ctrl.sv
// ============================================================================
// Module  : regfile_access_ctrl
// Brief   : Sequences 8085 register-file accesses with setup/strobe/hold phasing
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_access_ctrl #(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_sel,
  output logic       bc_rw,
  output logic       de_rw,
  output logic       hl_rw,
  output logic       wz_rw,
  output logic       pc_rw,
  output logic       sp_rw,
  output logic       rreg_rd,
  output logic       lreg_rd,
  output logic       rreg_wr,
  output logic       lreg_wr,
  output logic       dreg_rd,
  output logic       dreg_wr,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int c_cnt_max = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_setup_last  = c_cnt_w'(SETUP_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_strobe_last = c_cnt_w'(STROBE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_one         = c_cnt_w'(1);
  localparam logic [2:0] c_op_rd_pair = 3'd4;
  localparam logic [2:0] c_op_wr_pair = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_op, w_op_nxt;
  logic [2:0]         r_sel, w_sel_nxt;
  logic               r_byte, w_byte_nxt;
  logic               r_illegal, w_illegal_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;

  logic               r_ready, r_busy, r_done, r_err;
  logic [5:0]         r_sel_oh, r_strobe;
  logic [5:0]         w_sel_oh_nxt, w_strobe_nxt;
  logic               w_done_nxt, w_err_nxt, w_pair_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_sel     <= '0;
      r_byte    <= 1'b0;
      r_illegal <= 1'b0;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_sel_oh  <= '0;
      r_strobe  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_op      <= w_op_nxt;
      r_sel     <= w_sel_nxt;
      r_byte    <= w_byte_nxt;
      r_illegal <= w_illegal_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ready   <= (w_state_nxt == ST_IDLE);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_sel_oh  <= w_sel_oh_nxt;
      r_strobe  <= w_strobe_nxt;
    end
  end

  // Outputs are registered from the next-state values so they change exactly on phase entry.
  always_comb begin
    w_state_nxt   = r_state;
    w_op_nxt      = r_op;
    w_sel_nxt     = r_sel;
    w_byte_nxt    = r_byte;
    w_illegal_nxt = r_illegal;
    w_cnt_nxt     = r_cnt + c_one;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (cmd_valid) begin
          w_op_nxt      = cmd_op;
          w_sel_nxt     = cmd_sel;
          w_byte_nxt    = 1'b0;
          w_illegal_nxt = (cmd_sel > 3'd5);
          if (cmd_sel > 3'd5) w_state_nxt = ST_HOLD;
          else                w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (r_cnt == c_setup_last) begin
          w_state_nxt = ST_STROBE;
          w_cnt_nxt   = '0;
        end
      end
      ST_STROBE: begin
        if (r_cnt == c_strobe_last) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_cnt_nxt = '0;
        if (!r_illegal && !r_byte && (r_op == c_op_rd_pair || r_op == c_op_wr_pair)) begin
          w_state_nxt = ST_SETUP;
          w_byte_nxt  = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase

    w_pair_nxt   = (w_op_nxt == c_op_rd_pair) || (w_op_nxt == c_op_wr_pair);
    w_done_nxt   = (w_state_nxt == ST_HOLD) && (w_illegal_nxt || !w_pair_nxt || w_byte_nxt);
    w_err_nxt    = (w_state_nxt == ST_HOLD) && w_illegal_nxt;
    w_sel_oh_nxt = '0;
    if (w_state_nxt != ST_IDLE && !w_illegal_nxt) w_sel_oh_nxt = 6'b1 << w_sel_nxt;

    // Strobe bits: {dreg_wr, dreg_rd, lreg_wr, rreg_wr, lreg_rd, rreg_rd}
    w_strobe_nxt = '0;
    if (w_state_nxt == ST_STROBE) begin
      case (w_op_nxt)
        3'd0:    w_strobe_nxt = 6'b000001;
        3'd1:    w_strobe_nxt = 6'b000010;
        3'd2:    w_strobe_nxt = 6'b000100;
        3'd3:    w_strobe_nxt = 6'b001000;
        3'd4:    w_strobe_nxt = w_byte_nxt ? 6'b000010 : 6'b000001;
        3'd5:    w_strobe_nxt = w_byte_nxt ? 6'b001000 : 6'b000100;
        3'd6:    w_strobe_nxt = 6'b010000;
        default: w_strobe_nxt = 6'b100000;
      endcase
    end
  end

  assign cmd_ready = r_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign {sp_rw, pc_rw, wz_rw, hl_rw, de_rw, bc_rw} = r_sel_oh;
  assign {dreg_wr, dreg_rd, lreg_wr, rreg_wr, lreg_rd, rreg_rd} = r_strobe;

endmodule

`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
// ============================================================================
// Module  : tb_regfile_access_ctrl
// Brief   : Randomised and directed bench for regfile_access_ctrl (two param sets)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_access_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cmd_valid, cmd_ready, busy, done, err;
  logic [2:0] op0, op1, sel0, sel1;
  logic [5:0] rw0, rw1, st0, st1;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  regfile_access_ctrl #(.SETUP_CYCLES(1), .STROBE_CYCLES(1)) dut0 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(op0), .cmd_sel(sel0),
    .bc_rw(rw0[0]), .de_rw(rw0[1]), .hl_rw(rw0[2]), .wz_rw(rw0[3]), .pc_rw(rw0[4]), .sp_rw(rw0[5]),
    .rreg_rd(st0[0]), .lreg_rd(st0[1]), .rreg_wr(st0[2]), .lreg_wr(st0[3]),
    .dreg_rd(st0[4]), .dreg_wr(st0[5]),
    .busy(busy[0]), .done(done[0]), .err(err[0])
  );

  regfile_access_ctrl #(.SETUP_CYCLES(2), .STROBE_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(op1), .cmd_sel(sel1),
    .bc_rw(rw1[0]), .de_rw(rw1[1]), .hl_rw(rw1[2]), .wz_rw(rw1[3]), .pc_rw(rw1[4]), .sp_rw(rw1[5]),
    .rreg_rd(st1[0]), .lreg_rd(st1[1]), .rreg_wr(st1[2]), .lreg_wr(st1[3]),
    .dreg_rd(st1[4]), .dreg_wr(st1[5]),
    .busy(busy[1]), .done(done[1]), .err(err[1])
  );

  // Observation vector: {ready, busy, done, err, selects[5:0], strobes[5:0]}
  function automatic logic [15:0] sample(int d);
    if (d == 0) return {cmd_ready[0], busy[0], done[0], err[0], rw0, st0};
    return {cmd_ready[1], busy[1], done[1], err[1], rw1, st1};
  endfunction

  task automatic drive(int d, logic v, logic [2:0] op, logic [2:0] sel);
    if (d == 0) begin cmd_valid[0] = v; op0 = op; sel0 = sel; end
    else        begin cmd_valid[1] = v; op1 = op; sel1 = sel; end
  endtask

  // Reference: expected per-cycle outputs from the cycle after acceptance to the final hold.
  function automatic void model_push(int d, logic [2:0] op, logic [2:0] sel);
    int su = (d == 0) ? 1 : 2;
    int sc = (d == 0) ? 1 : 3;
    int nb = (op == 3'd4 || op == 3'd5) ? 2 : 1;
    logic [5:0] s;
    logic [5:0] strb;
    logic hi;
    if (sel > 3'd5) begin
      exp_q.push_back({4'b0111, 12'h000});
      return;
    end
    s = 6'b000001 << sel;
    for (int b = 0; b < nb; b++) begin
      hi = (op == 3'd1) || (op == 3'd3) || (nb == 2 && b == 1);
      if (op == 3'd6)                                 strb = 6'b010000;
      else if (op == 3'd7)                            strb = 6'b100000;
      else if (op == 3'd0 || op == 3'd1 || op == 3'd4) strb = hi ? 6'b000010 : 6'b000001;
      else                                            strb = hi ? 6'b001000 : 6'b000100;
      for (int i = 0; i < su; i++) exp_q.push_back({4'b0100, s, 6'b000000});
      for (int i = 0; i < sc; i++) exp_q.push_back({4'b0100, s, strb});
      exp_q.push_back({1'b0, 1'b1, (b == nb - 1), 1'b0, s, 6'b000000});
    end
  endfunction

  // Entered and left at a negedge with the DUT idle.
  task automatic exec(int d, logic [2:0] op, logic [2:0] sel, bit junk, string name);
    logic [15:0] obs, ex;
    int n;
    drive(d, 1'b1, op, sel);
    obs = sample(d);
    total++;
    if (obs !== 16'h8000) begin
      bad++;
      $display("FAIL %s pre-accept: got %h want %h", name, obs, 16'h8000);
    end
    @(posedge clk);
    model_push(d, op, sel);
    n = exp_q.size();
    for (int k = 1; k <= n; k++) begin
      #1;
      if (junk) drive(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      else      drive(d, 1'b0, 3'd0, 3'd0);
      @(negedge clk);
      obs = sample(d);
      ex  = exp_q.pop_front();
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL %s cycle %0d: got %h want %h", name, k, obs, ex);
      end
      @(posedge clk);
    end
    #1 drive(d, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    obs = sample(d);
    total++;
    if (obs !== 16'h8000) begin
      bad++;
      $display("FAIL %s idle-after: got %h want %h", name, obs, 16'h8000);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 1'b1, 3'd2, 3'd2);
    drive(1, 1'b1, 3'd2, 3'd2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(0, 1'b0, 3'd0, 3'd0);
    drive(1, 1'b0, 3'd0, 3'd0);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++;
      if (sample(d) !== 16'h8000) begin
        bad++;
        $display("FAIL reset dut%0d: got %h want %h", d, sample(d), 16'h8000);
      end
    end
  endtask

  task automatic test_directed();
    exec(0, 3'd2, 3'd2, 1'b0, "wr_l_hl");
    exec(0, 3'd4, 3'd4, 1'b1, "rd_pair_pc");
    exec(0, 3'd5, 3'd7, 1'b0, "illegal_sel");
    exec(1, 3'd2, 3'd2, 1'b1, "slow_wr_l");
    exec(1, 3'd5, 3'd3, 1'b0, "slow_wr_pair");
  endtask

  task automatic test_back_to_back();
    logic [15:0] obs, ex;
    drive(0, 1'b1, 3'd6, 3'd0);
    @(posedge clk);
    #1 drive(0, 1'b1, 3'd3, 3'd5);
    model_push(0, 3'd6, 3'd0);
    exp_q.push_back(16'h8000);
    model_push(0, 3'd3, 3'd5);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      obs = sample(0);
      ex  = exp_q.pop_front();
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL back_to_back cycle %0d: got %h want %h", k, obs, ex);
      end
      @(posedge clk);
      #1;
      if (k == 4) drive(0, 1'b0, 3'd0, 3'd0);
    end
    @(negedge clk);
    total++;
    if (sample(0) !== 16'h8000) begin
      bad++;
      $display("FAIL back_to_back idle: got %h want %h", sample(0), 16'h8000);
    end
  endtask

  task automatic test_rst_mid();
    logic [15:0] obs, ex;
    drive(0, 1'b1, 3'd5, 3'd1);
    @(posedge clk);
    #1 drive(0, 1'b0, 3'd0, 3'd0);
    model_push(0, 3'd5, 3'd1);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) rst = 1'b1;
      @(negedge clk);
      obs = sample(0);
      ex  = exp_q.pop_front();
      total++;
      if (obs !== ex) begin
        bad++;
        $display("FAIL rst_mid cycle %0d: got %h want %h", k, obs, ex);
      end
      @(posedge clk);
      #1;
    end
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (sample(0) !== 16'h8000) begin
      bad++;
      $display("FAIL rst_mid cycle 5: got %h want %h", sample(0), 16'h8000);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int d = (i % 4 == 3) ? 1 : 0;
      exec(d, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 3'd0, 3'd0);
    drive(1, 1'b0, 3'd0, 3'd0);
    test_reset();
    test_directed();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
